// File: rtl/ws2812b_rx_periph.sv
// WS2812B serial receiver peripheral: decodes 24-bit GRB pixels from DIN into readable holding registers.
// Optional chain pass-through of DIN while forwarding is enabled by defining WS2812B_RX_FWD_EN.
`timescale 1ns/1ps
module ws2812b_rx_periph #(
  parameter int RESET_CYCLES = 3200,
  parameter int THRESH_RST   = 38
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [7:0] uo_out
);

  localparam logic [11:0] GAP = 12'(RESET_CYCLES);
  localparam logic [7:0]  TH0 = 8'(THRESH_RST);

  typedef enum logic [2:0] {IDLE, HIGH, LOW, FWD, ERR} state_t;

  state_t      state_q, state_d;
  logic        din_q, din_d;
  logic [23:0] sr_q, sr_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic [11:0] lcnt_q, lcnt_d;
  logic [7:0]  g_q, g_d, r_q, r_d, b_q, b_d;
  logic        valid_q, valid_d, ovr_q, ovr_d, err_q, err_d;
  logic [7:0]  thresh_q, thresh_d;
  logic [7:0]  fcnt_q, fcnt_d;

  logic        din, rise, fall, bit_v, hw_valid, hw_err, wr_stat, busy, dout;
  logic [23:0] sr_shift;
  logic        unused_ui;

  assign din       = ui_in[1];
  assign unused_ui = ^{ui_in[7:2], ui_in[0]};
  assign rise      = din & ~din_q;
  assign fall      = ~din & din_q;
  assign bit_v     = hcnt_q > thresh_q;
  assign sr_shift  = {sr_q[22:0], bit_v};
  assign wr_stat   = data_write && (address == 4'd3);
  assign busy      = (state_q == HIGH) || (state_q == LOW) || (state_q == FWD);

  always_comb begin
    state_d  = state_q;
    din_d    = din;
    sr_d     = sr_q;
    bitcnt_d = bitcnt_q;
    hcnt_d   = hcnt_q;
    lcnt_d   = lcnt_q;
    g_d      = g_q;
    r_d      = r_q;
    b_d      = b_q;
    fcnt_d   = fcnt_q;
    hw_valid = 1'b0;
    hw_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d  = HIGH;
          hcnt_d   = 8'd1;
          bitcnt_d = 5'd0;
        end
      end
      HIGH: begin
        if (fall) begin
          sr_d     = sr_shift;
          bitcnt_d = bitcnt_q + 5'd1;
          lcnt_d   = 12'd1;
          if (bitcnt_q == 5'd23) begin
            // Full pixel: latch from the freshly shifted word so bit 0 is included.
            g_d      = sr_shift[23:16];
            r_d      = sr_shift[15:8];
            b_d      = sr_shift[7:0];
            fcnt_d   = fcnt_q + 8'd1;
            hw_valid = 1'b1;
            state_d  = FWD;
          end else begin
            state_d = LOW;
          end
        end else if (hcnt_q == 8'd254) begin
          hcnt_d  = 8'd255;
          lcnt_d  = 12'd0;
          hw_err  = 1'b1;
          state_d = ERR;
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
          hcnt_d  = 8'd1;
        end else if (lcnt_q == GAP) begin
          state_d = IDLE;
          lcnt_d  = 12'd0;
        end else begin
          lcnt_d = lcnt_q + 12'd1;
        end
      end
      FWD, ERR: begin
        if (lcnt_q == GAP) begin
          state_d = IDLE;
          lcnt_d  = 12'd0;
        end else if (din) begin
          lcnt_d = 12'd0;
        end else begin
          lcnt_d = lcnt_q + 12'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Hardware set wins over a software clear in the same cycle.
    valid_d = hw_valid ? 1'b1 : ((wr_stat && data_in[0]) ? 1'b0 : valid_q);
    ovr_d   = (hw_valid && valid_q) ? 1'b1 : ((wr_stat && data_in[1]) ? 1'b0 : ovr_q);
    err_d   = hw_err ? 1'b1 : ((wr_stat && data_in[3]) ? 1'b0 : err_q);
    thresh_d = (data_write && (address == 4'd4)) ? data_in : thresh_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      din_q    <= 1'b0;
      sr_q     <= 24'd0;
      bitcnt_q <= 5'd0;
      hcnt_q   <= 8'd0;
      lcnt_q   <= 12'd0;
      g_q      <= 8'd0;
      r_q      <= 8'd0;
      b_q      <= 8'd0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
      err_q    <= 1'b0;
      thresh_q <= TH0;
      fcnt_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      din_q    <= din_d;
      sr_q     <= sr_d;
      bitcnt_q <= bitcnt_d;
      hcnt_q   <= hcnt_d;
      lcnt_q   <= lcnt_d;
      g_q      <= g_d;
      r_q      <= r_d;
      b_q      <= b_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
      err_q    <= err_d;
      thresh_q <= thresh_d;
      fcnt_q   <= fcnt_d;
    end
  end

  always_comb begin
    data_out = 8'd0;
    case (address)
      4'd0:    data_out = g_q;
      4'd1:    data_out = r_q;
      4'd2:    data_out = b_q;
      4'd3:    data_out = {4'b0, err_q, busy, ovr_q, valid_q};
      4'd4:    data_out = thresh_q;
      4'd5:    data_out = fcnt_q;
      default: data_out = 8'd0;
    endcase
  end

`ifdef WS2812B_RX_FWD_EN
  assign dout = din & (state_q == FWD);
`else
  assign dout = 1'b0;
`endif

  assign uo_out = {5'b0, valid_q, dout, 1'b0};

endmodule

// File: tb/tb_ws2812b_rx_periph.sv
// Self-checking bench for ws2812b_rx_periph: scoreboard of expected pixels, one task per scenario.
`timescale 1ns/1ps
module tb_ws2812b_rx_periph;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in = 8'd0;
  logic [3:0] address = 4'd0;
  logic       data_write = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic [7:0] data_out;
  logic [7:0] uo_out;

  int n_cmp = 0;
  int n_bad = 0;
  int tb_thresh = 38;
  logic [7:0]  fcnt_exp = 8'd0;
  logic [23:0] exp_q[$];
  logic [23:0] last_pix = 24'd0;

  ws2812b_rx_periph dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .address(address),
    .data_write(data_write), .data_in(data_in), .data_out(data_out), .uo_out(uo_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic read_reg(input logic [3:0] a, output logic [7:0] v);
    @(negedge clk);
    address = a;
    #1;
    v = data_out;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a;
    data_in = d;
    data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ui_in[1] = 1'b0;
    end
  endtask

  task automatic send_level(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      ui_in[1] = v;
    end
  endtask

  // Sends the top n bits of d MSB-first; a full frame pushes the modelled decode.
  task automatic send_bits(input logic [23:0] d, input int n);
    logic [23:0] w;
    int hi, lo;
    w = 24'd0;
    for (int i = 23; i > 23 - n; i--) begin
      hi = d[i] ? 51 : 26;
      lo = d[i] ? 29 : 54;
      w[i] = (hi > tb_thresh);
      send_level(1'b1, hi);
      send_level(1'b0, lo);
    end
    if (n == 24) begin
      exp_q.push_back(w);
      fcnt_exp = fcnt_exp + 8'd1;
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    logic [7:0] exp_r [6];
    exp_r = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd38, 8'd0};
    repeat (3) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      read_reg(4'(k), v);
      n_cmp++;
      if (v !== exp_r[k]) begin
        n_bad++;
        $display("FAIL reset_reg%0d: got %h expected %h", k, v, exp_r[k]);
      end
    end
    n_cmp++;
    if (uo_out !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_uo_out: got %h expected 00", uo_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
  endtask

  task automatic check_pixel(input string name);
    logic [7:0] v;
    logic [23:0] pix;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s_queue: got empty expected one pixel", name);
      return;
    end
    pix = exp_q.pop_front();
    last_pix = pix;
    for (int k = 0; k < 3; k++) begin
      read_reg(4'(k), v);
      n_cmp++;
      if (v !== pix[23-8*k -: 8]) begin
        n_bad++;
        $display("FAIL %s_reg%0d: got %h expected %h", name, k, v, pix[23-8*k -: 8]);
      end
    end
    read_reg(4'd5, v);
    n_cmp++;
    if (v !== fcnt_exp) begin
      n_bad++;
      $display("FAIL %s_fcnt: got %0d expected %0d", name, v, fcnt_exp);
    end
  endtask

  task automatic test_frame();
    logic [7:0] v;
    send_bits(24'hFF0080, 24);
    read_reg(4'd3, v);
    n_cmp++;
    if (v !== 8'h05) begin
      n_bad++;
      $display("FAIL frame_status_busy: got %h expected 05", v);
    end
    n_cmp++;
    if (uo_out !== 8'h04) begin
      n_bad++;
      $display("FAIL frame_uo_out: got %h expected 04", uo_out);
    end
    check_pixel("frame");
    idle(3210);
    read_reg(4'd3, v);
    n_cmp++;
    if (v !== 8'h01) begin
      n_bad++;
      $display("FAIL frame_status_gap: got %h expected 01", v);
    end
  endtask

  task automatic test_forward();
    logic [23:0] d2;
    logic ex;
    int hi, lo;
    write_reg(4'd3, 8'h0B);
    d2 = 24'h3CA55A;
    send_bits(24'h12C7E1, 24);
    for (int i = 23; i >= 0; i--) begin
      hi = d2[i] ? 51 : 26;
      lo = d2[i] ? 29 : 54;
      for (int c = 0; c < hi + lo; c++) begin
        @(negedge clk);
        ui_in[1] = (c < hi);
        #1;
`ifdef WS2812B_RX_FWD_EN
        ex = ui_in[1];
`else
        ex = 1'b0;
`endif
        n_cmp++;
        if (uo_out[1] !== ex) begin
          n_bad++;
          $display("FAIL fwd_dout bit%0d cyc%0d: got %b expected %b", i, c, uo_out[1], ex);
        end
      end
    end
    idle(3210);
    check_pixel("forward");
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    send_bits(24'h0F8001, 24);
    idle(3210);
    read_reg(4'd3, v);
    n_cmp++;
    if (v !== 8'h03) begin
      n_bad++;
      $display("FAIL ovr_status: got %h expected 03", v);
    end
    check_pixel("ovr");
    write_reg(4'd3, 8'h03);
    read_reg(4'd3, v);
    n_cmp++;
    if (v !== 8'h00) begin
      n_bad++;
      $display("FAIL ovr_clear: got %h expected 00", v);
    end
  endtask

  task automatic test_error();
    logic [7:0] v;
    send_level(1'b1, 300);
    idle(2);
    read_reg(4'd3, v);
    n_cmp++;
    if (v !== 8'h08) begin
      n_bad++;
      $display("FAIL err_status: got %h expected 08", v);
    end
    for (int k = 0; k < 3; k++) begin
      read_reg(4'(k), v);
      n_cmp++;
      if (v !== last_pix[23-8*k -: 8]) begin
        n_bad++;
        $display("FAIL err_hold_reg%0d: got %h expected %h", k, v, last_pix[23-8*k -: 8]);
      end
    end
    idle(3210);
    send_bits(24'hA1B2C3, 24);
    idle(3210);
    check_pixel("err_recover");
    read_reg(4'd3, v);
    n_cmp++;
    if (v !== 8'h09) begin
      n_bad++;
      $display("FAIL err_recover_status: got %h expected 09", v);
    end
    write_reg(4'd3, 8'h0B);
  endtask

  task automatic test_thresh();
    logic [7:0] v;
    write_reg(4'd4, 8'd20);
    tb_thresh = 20;
    read_reg(4'd4, v);
    n_cmp++;
    if (v !== 8'd20) begin
      n_bad++;
      $display("FAIL thresh_read: got %0d expected 20", v);
    end
    send_bits(24'h000000, 12);
    idle(3210);
    read_reg(4'd3, v);
    n_cmp++;
    if (v !== 8'h00) begin
      n_bad++;
      $display("FAIL partial_status: got %h expected 00", v);
    end
    send_bits(24'h000000, 24);
    idle(3210);
    check_pixel("thresh");
    write_reg(4'd4, 8'd38);
    tb_thresh = 38;
    write_reg(4'd3, 8'h0B);
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    logic [7:0] exp_r [6];
    exp_r = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd38, 8'd0};
    write_reg(4'd4, 8'd45);
    send_bits(24'hFFFFFF, 10);
    @(negedge clk);
    rst_n = 1'b0;
    fcnt_exp = 8'd0;
    for (int k = 0; k < 6; k++) begin
      read_reg(4'(k), v);
      n_cmp++;
      if (v !== exp_r[k]) begin
        n_bad++;
        $display("FAIL midreset_reg%0d: got %h expected %h", k, v, exp_r[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    send_bits(24'h5AC33C, 24);
    idle(3210);
    check_pixel("midreset");
  endtask

  initial begin
    test_reset();
    test_frame();
    test_forward();
    test_back_to_back();
    test_error();
    test_thresh();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ws2812b_rx_periph.md
WS2812B_RX_PERIPH -- requirements
Module: ws2812b_rx_periph

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 3200, meaning line-low cycles that end a frame (50 us at 64 MHz).
REQ-002 SHALL have parameter THRESH_RST, default 38, meaning the reset value of the bit-decision threshold register.
REQ-003 SHALL have ports: clk  in  1  project clock (64 MHz); rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: ui_in  in  8  input PMOD, where ui_in[1] = DIN, the WS2812B serial input; address  in  4  register select.
REQ-005 SHALL have ports: data_write  in  1  write strobe; data_in  in  8  write data; data_out  out  8  read data (combinational on address).
REQ-006 SHALL have port uo_out  out  8: [0]=0 (UART TX reserved), [1]=DOUT, [2]=VALID status, [7:3]=0.

Function
REQ-007 SHALL register DIN once into din_q; rise = DIN & ~din_q; fall = ~DIN & din_q.
REQ-008 SHALL implement states IDLE, HIGH, LOW, FWD, ERR; IDLE after reset.
REQ-009 IDLE: rise -> HIGH, hcnt=1, bitcnt=0.
REQ-010 HIGH: hcnt increments per cycle, saturating at 255; fall -> shift bit (hcnt > thresh) MSB-first into 24-bit shift register, bitcnt+1, lcnt=1, -> LOW; hcnt reaching 255 -> ERR, set ERR flag, discard partial frame.
REQ-011 LOW: lcnt (12-bit) increments; rise -> HIGH with hcnt=1; lcnt == RESET_CYCLES -> IDLE, partial frame (<24 bits) discarded silently.
REQ-012 On the clock edge shifting bit 24: G=sr[23:16], R=sr[15:8], B=sr[7:0] latched into holding regs; if VALID already set, set OVR; set VALID; frame counter +1 (8-bit, 255 wraps to 0); next state FWD.
REQ-013 FWD: lcnt counts consecutive low cycles, cleared on any high; lcnt == RESET_CYCLES -> IDLE.
REQ-014 ERR: same reset-gap detection as FWD; -> IDLE on gap; no bits captured.
REQ-015 Register map read: 0=G, 1=R, 2=B, 3=status {4'b0, ERR, BUSY, OVR, VALID}, 4=thresh, 5=frame count, others 0.
REQ-016 BUSY SHALL be 1 in states HIGH, LOW, FWD.
REQ-017 Write addr 3: data_in[0]=1 clears VALID, [1] clears OVR, [3] clears ERR; on the same cycle, setting by hardware takes priority over clearing.
REQ-018 Write addr 4 loads thresh; takes effect for the next fall decision; other addresses are not writable.
REQ-019 Holding registers SHALL change only on a 24th-bit edge; reads never disturb state.

Reset
REQ-020 rst_n low: state IDLE; din_q, sr, bitcnt, hcnt, lcnt, G, R, B, status, frame count = 0; thresh = THRESH_RST; uo_out = 0; data_out = 0 at address 0.
REQ-021 Reset mid-frame SHALL discard all partial data; the first rise after release starts a new frame.

Configuration
REQ-022 Macro WS2812B_RX_FWD_EN defined: uo_out[1] = DIN while state == FWD, else 0 (chain pass-through, 0 cycles latency from ui_in).
REQ-023 WS2812B_RX_FWD_EN undefined: uo_out[1] = 0 constantly; FWD state and gap detection still apply.

Verification
REQ-024 Send 24 bits 0xFF0080 (T1H=51/T1L=29, T0H=26/T0L=54 cycles) -> G=0xFF, R=0x00, B=0x80, VALID=1, frame count=1, uo_out[2]=1.
REQ-025 Send 48 bits after a 3200-cycle gap, with FWD_EN defined -> second 24 bits appear on uo_out[1] cycle-identical to DIN; holding regs keep the first pixel; without FWD_EN uo_out[1] stays 0.
REQ-026 Send two frames separated by a 3200-cycle gap without clearing -> OVR=1; write 0x03 to addr 3 -> status reads 0x00 (BUSY=0 after gap).
REQ-027 High pulse of 300 cycles -> ERR=1, no latch; 3200-cycle low then valid frame -> captured correctly.
REQ-028 Write thresh=20, send bit with high time 26 cycles -> decoded as 1; 12 bits then 3200-cycle gap -> no VALID, state IDLE.
REQ-029 Assert rst_n after 10 bits -> all registers at reset values; next full frame decodes correctly.
